jamma_joy_responder: RTL and testbench

- Adapter-side responder for the multiplexed JAMMA joystick bus.
- The core drives JSELECT and samples an 8-bit active-low bus on each phase: select low = player 1, select high = player 2.
- This block synchronises JSELECT, debounces both players' raw harness inputs, and drives the selected player's stable bits onto the shared bus after a settle guard.
- It sits in the interface CPLD/FPGA between the JAMMA harness and the core's JJOY pins.

---
 rtl/jamma_joy_responder.sv | 172 +++++++++++++++++
 tb/tb_jamma_joy_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/jamma_joy_responder.sv
// Adapter-side responder for the multiplexed JAMMA joystick bus: synchronises the
// core's player select, debounces both harnesses and drives the selected player.
module jamma_joy_responder #(
  parameter int unsigned DEB_MAX = 15,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned WD_BITS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       jselect,
  input  logic [7:0] p1_raw,
  input  logic [7:0] p2_raw,
  output logic [7:0] jjoy,
  output logic [7:0] p1_stable,
  output logic [7:0] p2_stable,
  output logic       sel_active
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRIVE  = 2'd2
  } state_t;

  localparam logic [7:0]         DEB_LAST    = 8'(DEB_MAX - 1);
  localparam logic [3:0]         SETTLE_LOAD = (SETTLE == 32'd0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [WD_BITS-1:0] WD_MAX      = {WD_BITS{1'b1}};
  localparam logic [WD_BITS-1:0] WD_PRE      = WD_MAX - {{(WD_BITS-1){1'b0}}, 1'b1};

  logic               sel_m_r, sel_s_r, sel_d_r;
  logic [1:0]         prime_r;
  logic [7:0]         p1_m_r, p1_s_r, p2_m_r, p2_s_r;
  logic [15:0]        stable_r;
  logic [7:0]         deb_cnt_r [16];
  logic [15:0]        sync_all_s;

  state_t             state_r, state_nxt;
  logic [3:0]         settle_r, settle_nxt;
  logic [WD_BITS-1:0] wd_r, wd_nxt;
  logic [7:0]         jjoy_r, jjoy_nxt;
  logic               sel_active_r, sel_active_nxt;

  logic               edge_s;
  logic               wd_timeout_s;
  logic [7:0]         sel_data_s;

  // Two-flop synchronisers plus the select delay flop used for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_m_r <= 1'b1;
      sel_s_r <= 1'b1;
      sel_d_r <= 1'b1;
      prime_r <= 2'd0;
      p1_m_r  <= 8'hFF;
      p1_s_r  <= 8'hFF;
      p2_m_r  <= 8'hFF;
      p2_s_r  <= 8'hFF;
    end else begin
      sel_m_r <= jselect;
      sel_s_r <= sel_m_r;
      sel_d_r <= sel_s_r;
      prime_r <= (prime_r == 2'd3) ? 2'd3 : prime_r + 2'd1;
      p1_m_r  <= p1_raw;
      p1_s_r  <= p1_m_r;
      p2_m_r  <= p2_raw;
      p2_s_r  <= p2_m_r;
    end
  end

  // The select pipeline resets to 1, so edges are ignored until it has filled with
  // real samples; otherwise a static-low select would look like an edge after reset.
  assign edge_s     = (prime_r == 2'd3) && (sel_s_r ^ sel_d_r);
  assign sync_all_s = {p2_s_r, p1_s_r};
  assign sel_data_s = sel_s_r ? stable_r[15:8] : stable_r[7:0];

  // Per-bit debounce: stable bit follows only after DEB_MAX consecutive differing cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_r <= 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
        deb_cnt_r[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (sync_all_s[i] == stable_r[i]) begin
          deb_cnt_r[i] <= 8'd0;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          stable_r[i]  <= sync_all_s[i];
          deb_cnt_r[i] <= 8'd0;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + 8'd1;
        end
      end
    end
  end

  assign wd_timeout_s = (wd_r == WD_MAX) || (wd_r == WD_PRE);

  // Next-state and bus value; a select edge outranks watchdog expiry
  always_comb begin
    state_nxt      = state_r;
    settle_nxt     = settle_r;
    wd_nxt         = wd_r;
    jjoy_nxt       = jjoy_r;
    sel_active_nxt = sel_active_r;
    if (edge_s) begin
      wd_nxt         = {WD_BITS{1'b0}};
      sel_active_nxt = 1'b1;
      if (SETTLE == 32'd0) begin
        state_nxt  = ST_DRIVE;
        settle_nxt = 4'd0;
        jjoy_nxt   = sel_data_s;
      end else begin
        state_nxt  = ST_SETTLE;
        settle_nxt = SETTLE_LOAD;
        jjoy_nxt   = 8'hFF;
      end
    end else if (wd_timeout_s) begin
      wd_nxt         = WD_MAX;
      state_nxt      = ST_WAIT;
      settle_nxt     = 4'd0;
      jjoy_nxt       = 8'hFF;
      sel_active_nxt = 1'b0;
    end else begin
      wd_nxt = wd_r + {{(WD_BITS-1){1'b0}}, 1'b1};
      case (state_r)
        ST_WAIT: begin
          jjoy_nxt = 8'hFF;
        end
        ST_SETTLE: begin
          if (settle_r == 4'd0) begin
            state_nxt = ST_DRIVE;
            jjoy_nxt  = sel_data_s;
          end else begin
            settle_nxt = settle_r - 4'd1;
            jjoy_nxt   = 8'hFF;
          end
        end
        ST_DRIVE: begin
          jjoy_nxt = sel_data_s;
        end
        default: begin
          state_nxt = ST_WAIT;
          jjoy_nxt  = 8'hFF;
        end
      endcase
    end
  end

  // FSM, guard counter, watchdog and registered bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_WAIT;
      settle_r     <= 4'd0;
      wd_r         <= {WD_BITS{1'b0}};
      jjoy_r       <= 8'hFF;
      sel_active_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      settle_r     <= settle_nxt;
      wd_r         <= wd_nxt;
      jjoy_r       <= jjoy_nxt;
      sel_active_r <= sel_active_nxt;
    end
  end

  assign jjoy       = jjoy_r;
  assign sel_active = sel_active_r;
  assign p1_stable  = stable_r[7:0];
  assign p2_stable  = stable_r[15:8];

endmodule

// File: tb/tb_jamma_joy_responder.sv
// Directed bench for jamma_joy_responder: default instance plus a short-watchdog
// instance (WD_BITS = 4) sharing the same stimulus.
module tb_jamma_joy_responder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       jselect;
  logic [7:0] p1_raw, p2_raw;
  logic [7:0] jjoy, p1_stable, p2_stable;
  logic       sel_active;
  logic [7:0] wd_jjoy, wd_p1_stable, wd_p2_stable;
  logic       wd_sel_active;

  int checks = 0;
  int fails  = 0;

  jamma_joy_responder #(.DEB_MAX(15), .SETTLE(2), .WD_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .jselect(jselect), .p1_raw(p1_raw), .p2_raw(p2_raw),
    .jjoy(jjoy), .p1_stable(p1_stable), .p2_stable(p2_stable), .sel_active(sel_active)
  );

  jamma_joy_responder #(.DEB_MAX(15), .SETTLE(2), .WD_BITS(4)) dut_wd (
    .clk(clk), .reset_n(reset_n), .jselect(jselect), .p1_raw(p1_raw), .p2_raw(p2_raw),
    .jjoy(wd_jjoy), .p1_stable(wd_p1_stable), .p2_stable(wd_p2_stable),
    .sel_active(wd_sel_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    jselect = 1'b0;
    p1_raw  = 8'hFF;
    p2_raw  = 8'hFF;
    tick(3);
    chk("rst_jjoy", jjoy, 8'hFF);
    chk("rst_p1_stable", p1_stable, 8'hFF);
    chk("rst_sel_active", {7'd0, sel_active}, 8'd0);

    // Release with select static low: no edge, bus idle
    reset_n = 1'b1;
    tick(40);
    chk("idle_jjoy", jjoy, 8'hFF);
    chk("idle_sel_active", {7'd0, sel_active}, 8'd0);
    chk("idle_p1_stable", p1_stable, 8'hFF);
    chk("idle_wd_sel_active", {7'd0, wd_sel_active}, 8'd0);

    // Debounce latency: synced after 2 edges, stable 15 edges later
    p1_raw = 8'hFE;
    p2_raw = 8'hEF;
    tick(16);
    chk("deb_p1_before", p1_stable, 8'hFF);
    chk("deb_p2_before", p2_stable, 8'hFF);
    tick(1);
    chk("deb_p1_after", p1_stable, 8'hFE);
    chk("deb_p2_after", p2_stable, 8'hEF);
    tick(10);

    // Select high: FF at k+2..k+3, P2 data from k+4
    jselect = 1'b1;
    tick(2);
    chk("p2_k1_jjoy", jjoy, 8'hFF);
    chk("p2_k1_sel_active", {7'd0, sel_active}, 8'd0);
    tick(1);
    chk("p2_k2_jjoy", jjoy, 8'hFF);
    chk("p2_k2_sel_active", {7'd0, sel_active}, 8'd1);
    tick(1);
    chk("p2_k3_jjoy", jjoy, 8'hFF);
    tick(1);
    chk("p2_k4_jjoy", jjoy, 8'hEF);
    tick(27);
    chk("p2_hold_jjoy", jjoy, 8'hEF);

    // Select low: old data until the edge is seen, then guard, then P1
    jselect = 1'b0;
    tick(2);
    chk("p1_k1_jjoy", jjoy, 8'hEF);
    tick(1);
    chk("p1_k2_jjoy", jjoy, 8'hFF);
    tick(1);
    chk("p1_k3_jjoy", jjoy, 8'hFF);
    tick(1);
    chk("p1_k4_jjoy", jjoy, 8'hFE);
    tick(10);

    // 14-cycle glitch on bit 1 must not propagate
    p1_raw = 8'hFC;
    tick(14);
    p1_raw = 8'hFE;
    tick(20);
    chk("glitch_p1_stable", p1_stable, 8'hFE);
    chk("glitch_jjoy", jjoy, 8'hFE);

    // 15-cycle hold propagates; bus follows one cycle later
    p1_raw = 8'hFC;
    tick(16);
    chk("hold_p1_before", p1_stable, 8'hFE);
    tick(1);
    chk("hold_p1_after", p1_stable, 8'hFC);
    chk("hold_jjoy_pre", jjoy, 8'hFE);
    tick(1);
    chk("hold_jjoy_post", jjoy, 8'hFC);
    tick(3);

    // Second edge inside the guard restarts it; final level is P1
    jselect = 1'b1;
    tick(2);
    jselect = 1'b0;
    tick(1);
    chk("restart_t3_jjoy", jjoy, 8'hFF);
    tick(1);
    chk("restart_t4_jjoy", jjoy, 8'hFF);
    tick(1);
    chk("restart_t5_jjoy", jjoy, 8'hFF);
    tick(1);
    chk("restart_t6_jjoy", jjoy, 8'hFF);
    tick(1);
    chk("restart_t7_jjoy", jjoy, 8'hFC);
    chk("restart_wd_jjoy", wd_jjoy, 8'hFC);

    // Watchdog (WD_BITS = 4): last edge taken at t5, expiry 15 cycles later
    tick(12);
    chk("wd_before_jjoy", wd_jjoy, 8'hFC);
    chk("wd_before_sel_active", {7'd0, wd_sel_active}, 8'd1);
    tick(1);
    chk("wd_expire_jjoy", wd_jjoy, 8'hFF);
    chk("wd_expire_sel_active", {7'd0, wd_sel_active}, 8'd0);
    chk("wd_main_jjoy", jjoy, 8'hFC);
    chk("wd_main_sel_active", {7'd0, sel_active}, 8'd1);
    tick(10);
    chk("wd_idle_jjoy", wd_jjoy, 8'hFF);

    // Next edge revives the timed-out instance
    jselect = 1'b1;
    tick(2);
    chk("wd_revive_k1_sel", {7'd0, wd_sel_active}, 8'd0);
    chk("wd_revive_k1_jjoy", wd_jjoy, 8'hFF);
    tick(1);
    chk("wd_revive_k2_sel", {7'd0, wd_sel_active}, 8'd1);
    chk("wd_revive_k2_jjoy", wd_jjoy, 8'hFF);
    tick(2);
    chk("wd_revive_k4_jjoy", wd_jjoy, 8'hEF);
    chk("main_k4_jjoy", jjoy, 8'hEF);

    // Reset during a P1 DRIVE phase showing FE
    p1_raw  = 8'hFE;
    jselect = 1'b0;
    tick(25);
    chk("pre_reset_jjoy", jjoy, 8'hFE);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_jjoy", jjoy, 8'hFF);
    chk("async_rst_sel_active", {7'd0, sel_active}, 8'd0);
    chk("async_rst_p1_stable", p1_stable, 8'hFF);
    tick(2);
    reset_n = 1'b1;
    tick(30);
    chk("post_rst_jjoy", jjoy, 8'hFF);
    chk("post_rst_sel_active", {7'd0, sel_active}, 8'd0);
    jselect = 1'b1;
    tick(5);
    chk("post_rst_edge_jjoy", jjoy, 8'hEF);
    chk("post_rst_edge_sel_active", {7'd0, sel_active}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
